prng_pool_unit: RTL and testbench

//  Multi-channel randomness source for the masked datapath. One 128-bit maximal-length LFSR,

---
 rtl/prng_pool_if.sv | 23 ++
 rtl/prng_pool_unit.sv | 148 ++++++++++++++
 tb/tb_prng_pool_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/prng_pool_if.sv
// rtl/prng_pool_if.sv - seed feed and per-channel random word handshake bundle
interface prng_pool_if #(
    parameter int SIZE_FEED = 32,
    parameter int SIZE_RND  = 128,
    parameter int N_CH      = 2
);
    logic                     feed;
    logic [SIZE_FEED-1:0]     feed_data;
    logic [N_CH-1:0]          rnd_ready;
    logic [N_CH-1:0]          rnd_valid;
    logic [N_CH*SIZE_RND-1:0] rnd_out;
    logic                     seeded;

    modport master (
        output feed, feed_data, rnd_ready,
        input  rnd_valid, rnd_out, seeded
    );

    modport slave (
        input  feed, feed_data, rnd_ready,
        output rnd_valid, rnd_out, seeded
    );
endinterface

// File: rtl/prng_pool_unit.sv
// rtl/prng_pool_unit.sv - 128-bit LFSR filling N_CH round-robin random word buffers
module stage_ML_lfsr128 (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    // Right-shifting Fibonacci form of x^128 + x^126 + x^101 + x^99 + 1
    assign state_o = {state_i[0] ^ state_i[2] ^ state_i[27] ^ state_i[29], state_i[127:1]};
endmodule

module prng_pool_unit #(
    parameter int SIZE_RND  = 128,
    parameter int SIZE_GEN  = 4,
    parameter int SIZE_FEED = 32,
    parameter int N_CH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    prng_pool_if.slave  bus
);
    localparam int RND_LAT    = SIZE_RND / SIZE_GEN;
    localparam int SEED_BEATS = 128 / SIZE_FEED;
    localparam int CW         = $clog2(RND_LAT + 1);
    localparam int SW         = $clog2(SEED_BEATS + 1);
    localparam int PW         = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [127:0]        state_q, state_d;
    logic [SIZE_RND-1:0] word_q [N_CH];
    logic [SIZE_RND-1:0] word_d [N_CH];
    logic [CW-1:0]       cnt_q  [N_CH];
    logic [CW-1:0]       cnt_d  [N_CH];
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [SW-1:0]       seed_cnt_q, seed_cnt_d;

    logic [SIZE_GEN-1:0] q_bits;
    logic [127:0]        gen_state;
    logic [127:0]        fed_state;
    logic [SIZE_RND-1:0] fill_word;
    logic [N_CH-1:0]     full;
    logic [N_CH-1:0]     consume;
    logic                seeded;
    logic                gen;
    logic                complete;

    for (genvar i = 0; i < SIZE_GEN; i++) begin : g_stage
        logic [127:0] s_i;
        logic [127:0] s_o;
        if (i == 0) begin : g_first
            assign s_i = state_q;
        end else begin : g_next
            assign s_i = g_stage[i-1].s_o;
        end
        stage_ML_lfsr128 u_stage (.state_i(s_i), .state_o(s_o));
        assign q_bits[i] = s_o[0];
    end
    assign gen_state = g_stage[SIZE_GEN-1].s_o;

    if (SIZE_FEED == 128) begin : g_feed_all
        assign fed_state = bus.feed_data;
    end else begin : g_feed_part
        assign fed_state = {bus.feed_data, state_q[127:SIZE_FEED]};
    end

    // Fresh bits enter at the top so the oldest bits settle at the LSB
    if (SIZE_GEN == SIZE_RND) begin : g_fill_all
        assign fill_word = q_bits;
    end else begin : g_fill_part
        assign fill_word = {q_bits, word_q[ptr_q][SIZE_RND-1:SIZE_GEN]};
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign full[c] = (cnt_q[c] == CW'(RND_LAT));
        assign bus.rnd_out[c*SIZE_RND +: SIZE_RND] = word_q[c];
    end

    assign consume       = full & bus.rnd_ready;
    assign seeded        = (seed_cnt_q == SW'(SEED_BEATS));
    assign gen           = seeded & ~bus.feed & ~full[ptr_q];
    assign complete      = gen & (cnt_q[ptr_q] == CW'(RND_LAT - 1));
    assign bus.rnd_valid = full;
    assign bus.seeded    = seeded;

    always_comb begin
        logic found;
        int   idx;
        state_d    = state_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        seed_cnt_d = seed_cnt_q;
        found      = 1'b0;
        idx        = 0;

        for (int c = 0; c < N_CH; c++) begin
            if (consume[c]) cnt_d[c] = '0;
        end

        if (bus.feed) begin
            state_d = fed_state;
            for (int c = 0; c < N_CH; c++) cnt_d[c] = '0;
            ptr_d = '0;
            if (!seeded) seed_cnt_d = seed_cnt_q + SW'(1);
        end else if (gen) begin
            state_d        = gen_state;
            word_d[ptr_q]  = fill_word;
            cnt_d[ptr_q]   = cnt_q[ptr_q] + CW'(1);
            if (complete) begin
                // A channel consumed this cycle is already eligible for the next fill
                for (int k = 1; k < N_CH; k++) begin
                    idx = (int'(ptr_q) + k) % N_CH;
                    if (!found && (!full[idx] || consume[idx])) begin
                        ptr_d = PW'(idx);
                        found = 1'b1;
                    end
                end
                if (!found) ptr_d = PW'((int'(ptr_q) + 1) % N_CH);
            end
        end else if (full[ptr_q] && (|consume)) begin
            // Parked on a full channel: jump to the first channel freed this cycle
            for (int k = 0; k < N_CH; k++) begin
                idx = (int'(ptr_q) + k) % N_CH;
                if (!found && consume[idx]) begin
                    ptr_d = PW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= '0;
            ptr_q      <= '0;
            seed_cnt_q <= '0;
            for (int c = 0; c < N_CH; c++) begin
                word_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            seed_cnt_q <= seed_cnt_d;
            for (int c = 0; c < N_CH; c++) begin
                word_q[c] <= word_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
        end
    end
endmodule

// File: tb/tb_prng_pool_unit.sv
// tb/tb_prng_pool_unit.sv - directed and random-ready checks of prng_pool_unit against an LFSR model
module tb_prng_pool_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    prng_pool_if #(.SIZE_FEED(32), .SIZE_RND(128), .N_CH(2)) ifa ();
    prng_pool_if #(.SIZE_FEED(32), .SIZE_RND(128), .N_CH(3)) ifb ();

    prng_pool_unit #(.SIZE_RND(128), .SIZE_GEN(4), .SIZE_FEED(32), .N_CH(2)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ifa)
    );
    prng_pool_unit #(.SIZE_RND(128), .SIZE_GEN(128), .SIZE_FEED(32), .N_CH(3)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb)
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] ma, mb;
    logic [127:0] w, w1_saved;
    logic [127:0] exp_q [$];
    logic [127:0] sb_b [3][$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(inout logic [127:0] s, output logic b);
        logic fb;
        fb = s[0] ^ s[2] ^ s[27] ^ s[29];
        s  = {fb, s[127:1]};
        b  = s[0];
    endtask

    task automatic model_word(inout logic [127:0] s, output logic [127:0] wd);
        logic b;
        for (int j = 0; j < 128; j++) begin
            model_step(s, b);
            wd[j] = b;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0]  seeds [4];
        logic [2:0]   pv, vb, rdy;
        logic [383:0] ob;
        logic         b;
        logic [2:0]   fill_pat [3];

        seeds[0] = 32'h1111_1111; seeds[1] = 32'h2222_2222;
        seeds[2] = 32'h3333_3333; seeds[3] = 32'h4444_4444;
        fill_pat[0] = 3'b001; fill_pat[1] = 3'b011; fill_pat[2] = 3'b111;

        rst_a = 1'b1; rst_b = 1'b1;
        ifa.feed = 1'b0; ifa.feed_data = '0; ifa.rnd_ready = '0;
        ifb.feed = 1'b0; ifb.feed_data = '0; ifb.rnd_ready = '0;
        tick; tick;
        chk("rst_valid", 128'(ifa.rnd_valid), 128'(2'b00));
        chk("rst_out0", ifa.rnd_out[127:0], 128'h0);
        chk("rst_seeded", 128'(ifa.seeded), 128'(1'b0));
        rst_a = 1'b0; rst_b = 1'b0;
        tick;

        // T1: three beats leave the unit unseeded and idle, the fourth seeds it
        for (int i = 0; i < 4; i++) begin
            ifa.feed = 1'b1;
            ifa.feed_data = seeds[i];
            tick;
            if (i < 3) begin
                ifa.feed = 1'b0;
                tick;
                chk("t1_unseeded", 128'(ifa.seeded), 128'(1'b0));
                chk("t1_no_valid", 128'(ifa.rnd_valid), 128'(2'b00));
            end
        end
        ifa.feed = 1'b0;
        chk("t1_seeded", 128'(ifa.seeded), 128'(1'b1));
        chk("t1_state", dut_a.state_q, 128'h44444444_33333333_22222222_11111111);
        ma = 128'h44444444_33333333_22222222_11111111;

        // T2: channel 0 full after 32 generate cycles, channel 1 after 64
        for (int i = 1; i <= 64; i++) begin
            tick;
            if (i == 31) chk("t2_valid31", 128'(ifa.rnd_valid), 128'(2'b00));
            if (i == 32) chk("t2_valid32", 128'(ifa.rnd_valid), 128'(2'b01));
            if (i == 63) chk("t2_valid63", 128'(ifa.rnd_valid), 128'(2'b01));
            if (i == 64) chk("t2_valid64", 128'(ifa.rnd_valid), 128'(2'b11));
        end
        chk("t2_seed_bits", {1'b0, ifa.rnd_out[126:0]},
            {1'b0, 128'h44444444_33333333_22222222_11111111 >> 1});
        model_word(ma, w); exp_q.push_back(w);
        model_word(ma, w); exp_q.push_back(w);
        repeat (5) tick;
        chk("t2_frozen_state", dut_a.state_q, ma);
        w = exp_q.pop_front();
        chk("t2_ch0_word", ifa.rnd_out[127:0], w);
        w1_saved = exp_q.pop_front();
        chk("t2_ch1_word", ifa.rnd_out[255:128], w1_saved);

        // T3: consume channel 0, it refills from the continuing stream
        ifa.rnd_ready = 2'b01;
        tick;
        ifa.rnd_ready = 2'b00;
        chk("t3_valid_after_take", 128'(ifa.rnd_valid), 128'(2'b10));
        chk("t3_ch1_hold", ifa.rnd_out[255:128], w1_saved);
        model_word(ma, w); exp_q.push_back(w);
        for (int i = 1; i <= 32; i++) begin
            tick;
            if (i == 31) chk("t3_valid31", 128'(ifa.rnd_valid), 128'(2'b10));
            if (i == 32) chk("t3_valid32", 128'(ifa.rnd_valid), 128'(2'b11));
        end
        w = exp_q.pop_front();
        chk("t3_ch0_refill", ifa.rnd_out[127:0], w);

        // T4: feed while channel 1 is 17 steps into its refill
        ifa.rnd_ready = 2'b10;
        tick;
        ifa.rnd_ready = 2'b00;
        chk("t4_valid_after_take", 128'(ifa.rnd_valid), 128'(2'b01));
        repeat (17) tick;
        for (int j = 0; j < 17 * 4; j++) model_step(ma, b);
        ifa.feed = 1'b1;
        ifa.feed_data = 32'hA5A5_5A5A;
        tick;
        ifa.feed = 1'b0;
        ma = {32'hA5A5_5A5A, ma[127:32]};
        chk("t4_valid_flushed", 128'(ifa.rnd_valid), 128'(2'b00));
        chk("t4_still_seeded", 128'(ifa.seeded), 128'(1'b1));
        chk("t4_state", dut_a.state_q, ma);
        for (int i = 1; i <= 32; i++) begin
            tick;
            if (i == 31) chk("t4_valid31", 128'(ifa.rnd_valid), 128'(2'b00));
            if (i == 32) chk("t4_valid32", 128'(ifa.rnd_valid), 128'(2'b01));
        end
        model_word(ma, w); exp_q.push_back(w);
        w = exp_q.pop_front();
        chk("t4_ch0_word", ifa.rnd_out[127:0], w);

        // T5: asynchronous reset between edges
        repeat (3) tick;
        #2 rst_a = 1'b1;
        #1;
        chk("t5_valid", 128'(ifa.rnd_valid), 128'(2'b00));
        chk("t5_out", ifa.rnd_out[255:128] | ifa.rnd_out[127:0], 128'h0);
        chk("t5_seeded", 128'(ifa.seeded), 128'(1'b0));
        tick;
        rst_a = 1'b0;

        // T6: one full word per cycle, three channels, random consumer
        mb = '0;
        for (int i = 0; i < 4; i++) begin
            ifb.feed = 1'b1;
            ifb.feed_data = $urandom;
            mb = {ifb.feed_data, mb[127:32]};
            tick;
        end
        ifb.feed = 1'b0;
        chk("t6_state", dut_b.state_q, mb);
        pv = 3'b000;
        for (int i = 0; i < 10000; i++) begin
            ifb.rnd_ready = (i < 3) ? 3'b000 : 3'($urandom);
            vb  = ifb.rnd_valid;
            ob  = ifb.rnd_out;
            rdy = ifb.rnd_ready;
            tick;
            if (i < 3) chk("t6_fill_order", 128'(ifb.rnd_valid), 128'(fill_pat[i]));
            for (int c = 0; c < 3; c++) begin
                if (vb[c] && rdy[c]) begin
                    if (sb_b[c].size() == 0) begin
                        chk("t6_sb_empty", 128'(sb_b[c].size()), 128'(1));
                    end else begin
                        w = sb_b[c].pop_front();
                        chk("t6_word", ob[c*128 +: 128], w);
                    end
                end
            end
            for (int c = 0; c < 3; c++) begin
                if (ifb.rnd_valid[c] && !pv[c]) begin
                    model_word(mb, w);
                    sb_b[c].push_back(w);
                end
            end
            pv = ifb.rnd_valid;
        end
        ifb.rnd_ready = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
